// File: rtl/iter_alu.sv
// iter_alu: handshaked integer ALU. One-cycle base ops, iterative MUL/DIVU/REMU.
// Ports: clk, rst_n, in_valid/in_ready/op/inp_A/inp_B in; out_valid/out_ready/result/zero_flag/illegal out.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inp_A,
    input  logic [WIDTH-1:0] inp_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIVU, K_REMU} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ill_q, ill_d;

    logic [WIDTH-1:0]   one_res;
    logic               one_ill;
    logic               go_iter;
    logic [WIDTH-1:0]   mul_acc;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   fin;

    // Single-cycle datapath. DIVU/REMU entries only matter for B==0,
    // since any non-zero divisor takes the iterative path.
    always_comb begin
        one_res = '0;
        one_ill = 1'b0;
        case (op)
            4'b0000: one_res = inp_A + inp_B;
            4'b0001: one_res = inp_A - inp_B;
            4'b0010: one_res = inp_A & inp_B;
            4'b0011: one_res = inp_A | inp_B;
            4'b0100: one_res = {{(WIDTH-1){1'b0}},
                                $signed(inp_A) < $signed(inp_B)};
            4'b0101: one_res = inp_A - inp_B;
            4'b0110: one_res = {{(WIDTH-1){1'b0}}, inp_A < inp_B};
            4'b1000: one_res = '0;
            4'b1001: one_res = '1;
            4'b1010: one_res = inp_A;
            default: one_ill = 1'b1;
        endcase
    end

    assign go_iter = (op == 4'b1000) ||
                     (((op == 4'b1001) || (op == 4'b1010)) && (inp_B != '0));

    // One shift-add step: a_q is the shifted multiplicand, b_q the
    // remaining multiplier bits.
    assign mul_acc = b_q[0] ? acc_q + a_q : acc_q;

    // One restoring-division step: a_q shifts dividend bits out at the top
    // and quotient bits in at the bottom; acc_q holds the partial remainder.
    assign rem_sh  = {acc_q, a_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign div_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign div_quo = {a_q[WIDTH-2:0], ~diff[WIDTH]};

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        fin     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (go_iter) begin
                        a_d     = inp_A;
                        b_d     = inp_B;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        kind_d  = (op == 4'b1000) ? K_MUL :
                                  (op == 4'b1001) ? K_DIVU : K_REMU;
                        state_d = BUSY;
                    end else begin
                        res_d   = one_res;
                        zero_d  = (one_res == '0);
                        ill_d   = one_ill;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (kind_q == K_MUL) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    fin   = mul_acc;
                end else begin
                    acc_d = div_rem;
                    a_d   = div_quo;
                    fin   = (kind_q == K_DIVU) ? div_quo : div_rem;
                end
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = fin;
                    zero_d  = (fin == '0);
                    ill_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= K_MUL;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign zero_flag = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized + directed scoreboard bench for iter_alu.
// Driver pushes model expectations; a negedge monitor pops on handoff.
module tb_iter_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] inp_A = '0;
    logic [W-1:0] inp_B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero_flag;
    logic         illegal;

    logic         v8 = 1'b0;
    logic         r8;
    logic [3:0]   op8 = '0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         ov8;
    logic [7:0]   res8;
    logic         z8;
    logic         ill8;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .inp_A(inp_A), .inp_B(inp_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .illegal(illegal)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8),
        .op(op8), .inp_A(a8), .inp_B(b8),
        .out_valid(ov8), .out_ready(1'b1),
        .result(res8), .zero_flag(z8), .illegal(ill8)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] res;
        logic         z;
        logic         ill;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_rdy = 0;
    bit   rdy_fixed = 1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    // Reference model: plain arithmetic. lat = edges from accept to valid.
    function automatic exp_t model(logic [3:0] o, logic [W-1:0] a,
                                   logic [W-1:0] b);
        exp_t e;
        e.op  = o;
        e.ill = 1'b0;
        e.lat = 0;
        e.t0  = 0;
        e.res = '0;
        case (o)
            4'd0:  e.res = a + b;
            4'd1:  e.res = a - b;
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:  e.res = a - b;
            4'd6:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd8:  begin e.res = a * b; e.lat = W; end
            4'd9:  if (b == 0) e.res = '1;
                   else begin e.res = a / b; e.lat = W; end
            4'd10: if (b == 0) e.res = a;
                   else begin e.res = a % b; e.lat = W; end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Monitor: hold-stability while waiting, compare on handoff.
    logic [W-1:0] h_res;
    logic         h_z, h_ill;
    bit           seen = 0;
    int           first = 0;
    exp_t         me;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL rdy_excl in_ready=%b want 0", in_ready);
            end
            if (!seen) begin
                seen  = 1;
                first = cyc;
                h_res = result;
                h_z   = zero_flag;
                h_ill = illegal;
            end else begin
                checks++;
                if (result !== h_res || zero_flag !== h_z || illegal !== h_ill) begin
                    errors++;
                    $display("FAIL hold res=%h want %h z=%b want %b ill=%b want %b",
                             result, h_res, zero_flag, h_z, illegal, h_ill);
                end
            end
            if (out_ready) begin
                seen = 0;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected result=%h", result);
                end else begin
                    me = sbq.pop_front();
                    if (result !== me.res || zero_flag !== me.z ||
                        illegal !== me.ill || (first - me.t0) != me.lat) begin
                        errors++;
                        $display("FAIL op%h res=%h want %h z=%b want %b ill=%b want %b lat=%0d want %0d",
                                 me.op, result, me.res, zero_flag, me.z,
                                 illegal, me.ill, first - me.t0, me.lat);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        op       = o;
        inp_A    = a;
        inp_B    = b;
        @(posedge clk);
        #1;
        e    = model(o, a, b);
        e.t0 = cyc;
        sbq.push_back(e);
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready in_ready=%b want 0", in_ready);
            end
        end
        in_valid = 1'b0;
        op       = 4'($urandom);
        inp_A    = $urandom;
        inp_B    = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", sbq.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 ||
            zero_flag !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset rdy=%b ov=%b res=%h z=%b ill=%b want 1 0 0 0 0",
                     in_ready, out_valid, result, zero_flag, illegal);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        int t0;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 0);
        drain();
        do_reset();

        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 0);
        issue(4'd4, 32'hFFFF_FFFF, 32'h1, 0);
        issue(4'd6, 32'hFFFF_FFFF, 32'h1, 0);
        issue(4'd5, 32'd5, 32'd5, 0);
        issue(4'd5, 32'd5, 32'd6, 0);
        issue(4'd8, 32'h1234_5678, 32'h10, 0);
        issue(4'd9, 32'd100, 32'd7, 0);
        issue(4'd10, 32'd100, 32'd7, 0);
        issue(4'd8, 32'hDEAD_BEEF, 32'h0000_0F0F, 10);
        issue(4'd9, 32'd9, 32'd0, 0);
        issue(4'd10, 32'd9, 32'd0, 0);
        drain();

        // Backpressure on an illegal op.
        rdy_fixed = 1'b0;
        @(posedge clk);
        #3;
        issue(4'hF, 32'h55, 32'hAA, 0);
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure ov=%b rdy=%b want 1 0",
                         out_valid, in_ready);
            end
        end
        rdy_fixed = 1'b1;
        @(posedge clk);
        #3;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        drain();

        // Reset during a DIVU: nothing may come out afterwards.
        issue(4'd9, 32'd100, 32'd7, 0);
        repeat (10) @(negedge clk);
        do_reset();
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort ov_cycles=%0d want 0", bad);
        end
        issue(4'd0, 32'd2, 32'd3, 0);
        drain();

        // WIDTH=8 multiply latency and value.
        @(negedge clk);
        v8  = 1'b1;
        op8 = 4'd8;
        a8  = 8'h0F;
        b8  = 8'h11;
        @(posedge clk);
        #1;
        t0 = cyc;
        v8 = 1'b0;
        a8 = 8'h00;
        n  = 0;
        @(negedge clk);
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ov8 || res8 !== 8'hFF || (cyc - t0) != 8 || ill8 !== 1'b0 || z8 !== 1'b0) begin
            errors++;
            $display("FAIL mul8 ov=%b res=%h want ff lat=%0d want 8",
                     ov8, res8, cyc - t0);
        end

        // Randomized traffic with random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            ro = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom;
            issue(ro, ra, rb, 0);
        end
        drain();
        rand_rdy = 0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
